// File: rtl/pos_pkg.sv
// Constants and helpers shared by every block that produces or consumes
// the four 20-bit position words.
package pos_pkg;

  localparam int POS_W = 20;

  localparam logic [POS_W-1:0] P0 = 20'h96A5A;
  localparam logic [POS_W-1:0] P1 = 20'hF0E5A;
  localparam logic [POS_W-1:0] P2 = 20'hAAA5A;
  localparam logic [POS_W-1:0] P3 = 20'h5565A;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] code;
  } match_t;

  // The words are all distinct, so the first exact match is the only one.
  function automatic match_t match_word(input logic [POS_W-1:0] word);
    match_t m;
    m.hit  = 1'b0;
    m.code = 2'b00;
    case (word)
      P0: begin m.hit = 1'b1; m.code = 2'd0; end
      P1: begin m.hit = 1'b1; m.code = 2'd1; end
      P2: begin m.hit = 1'b1; m.code = 2'd2; end
      P3: begin m.hit = 1'b1; m.code = 2'd3; end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pos_match.sv
// Combinational exact compare of one 20-bit window against the position words.
module pos_match
  import pos_pkg::*;
(
  input  logic [POS_W-1:0] word,
  output logic             hit,
  output logic [1:0]       code
);

  match_t m;

  assign m    = match_word(word);
  assign hit  = m.hit;
  assign code = m.code;

endmodule

// File: rtl/pos_pattern_detect.sv
// Serial position-word detector: finds the 20-bit words in an MSB-first
// bitstream, tracks frame alignment and reports recovered select codes.
module pos_pattern_detect
  import pos_pkg::*;
#(
  parameter int MISS_LIMIT = 3,
  parameter int MCNT_W     = 8
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              bit_in,
  input  logic              bit_vld,
  output logic              det_vld,
  output logic [1:0]        det_sel,
  output logic              det_err,
  output logic              locked,
  output logic [MCNT_W-1:0] good_cnt
);

  state_t           state;
  state_t           state_next;
  logic [POS_W-1:0] sr;
  logic [POS_W-1:0] window;
  logic [4:0]       fill;
  logic [4:0]       frame_cnt;
  logic [4:0]       frame_next;
  logic [3:0]       miss_cnt;
  logic [3:0]       miss_next;
  logic [3:0]       miss_inc;
  logic             fill_full;
  logic             boundary;
  logic             hit;
  logic [1:0]       code;
  logic             vld_next;
  logic             err_next;

  // Compare against what sr will hold once the current bit is shifted in.
  assign window    = {sr[POS_W-2:0], bit_in};
  assign fill_full = (fill >= 5'(POS_W - 1));
  assign boundary  = (frame_cnt == 5'(POS_W - 1));
  assign miss_inc  = miss_cnt + 4'd1;
  assign locked    = (state == LOCKED);

  pos_match u_match (
    .word (window),
    .hit  (hit),
    .code (code)
  );

  always_comb begin
    state_next = state;
    frame_next = frame_cnt;
    miss_next  = miss_cnt;
    if (bit_vld) begin
      case (state)
        SEARCH: begin
          if (fill_full && hit) begin
            state_next = LOCKED;
            frame_next = 5'd0;
            miss_next  = 4'd0;
          end
        end
        LOCKED: begin
          if (boundary) begin
            frame_next = 5'd0;
            if (hit) begin
              miss_next = 4'd0;
            end else if (miss_inc == 4'(MISS_LIMIT)) begin
              state_next = SEARCH;
              miss_next  = 4'd0;
            end else begin
              miss_next = miss_inc;
            end
          end else begin
            frame_next = frame_cnt + 5'd1;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_comb begin
    vld_next = 1'b0;
    err_next = 1'b0;
    if (bit_vld) begin
      case (state)
        SEARCH: vld_next = fill_full && hit;
        LOCKED: begin
          vld_next = boundary && hit;
          err_next = boundary && !hit;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= SEARCH;
      sr        <= '0;
      fill      <= 5'd0;
      frame_cnt <= 5'd0;
      miss_cnt  <= 4'd0;
      det_vld   <= 1'b0;
      det_err   <= 1'b0;
      det_sel   <= 2'b00;
      good_cnt  <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_next;
      miss_cnt  <= miss_next;
      det_vld   <= vld_next;
      det_err   <= err_next;
      if (bit_vld) begin
        sr <= window;
        if (fill != 5'(POS_W)) fill <= fill + 5'd1;
      end
      if (vld_next) det_sel <= code;
      if (vld_next && (good_cnt != '1)) good_cnt <= good_cnt + MCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pos_pattern_detect.sv
// Randomised bench for pos_pattern_detect, checked every cycle against a
// bit-history reference model of the detection rules.
module tb_pos_pattern_detect;

  localparam int MISS_LIMIT = 3;
  localparam int MCNT_W     = 8;
  localparam int CNT_MAX    = (1 << MCNT_W) - 1;

  logic              iclk;
  logic              irst;
  logic              bit_in;
  logic              bit_vld;
  logic              det_vld;
  logic [1:0]        det_sel;
  logic              det_err;
  logic              locked;
  logic [MCNT_W-1:0] good_cnt;

  int checks;
  int errors;

  logic [19:0] pat [4];

  int  m_win;
  int  m_fill;
  bit  m_locked;
  int  m_pos;
  int  m_miss;
  int  m_sel;
  int  m_good;
  bit  exp_vld;
  bit  exp_err;

  pos_pattern_detect #(
    .MISS_LIMIT (MISS_LIMIT),
    .MCNT_W     (MCNT_W)
  ) dut (
    .iclk     (iclk),
    .irst     (irst),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .det_vld  (det_vld),
    .det_sel  (det_sel),
    .det_err  (det_err),
    .locked   (locked),
    .good_cnt (good_cnt)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  function automatic int find_pat(input int w);
    for (int i = 0; i < 4; i++)
      if (int'(pat[i]) == w) return i;
    return -1;
  endfunction

  // Reference: bits since reset form a sliding window; alignment is a bit count.
  task automatic model_step(input logic b, input logic v);
    int idx;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (!v) return;
    m_win  = (m_win * 2 + int'(b)) % 1048576;
    m_fill = (m_fill < 20) ? m_fill + 1 : 20;
    idx    = find_pat(m_win);
    if (!m_locked) begin
      if (m_fill == 20 && idx >= 0) begin
        exp_vld  = 1'b1;
        m_locked = 1'b1;
        m_pos    = 0;
        m_miss   = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == 20) begin
        m_pos = 0;
        if (idx >= 0) begin
          exp_vld = 1'b1;
          m_miss  = 0;
        end else begin
          exp_err = 1'b1;
          m_miss++;
          if (m_miss == MISS_LIMIT) begin
            m_locked = 1'b0;
            m_miss   = 0;
          end
        end
      end
    end
    if (exp_vld) begin
      m_sel  = idx;
      m_good = (m_good < CNT_MAX) ? m_good + 1 : CNT_MAX;
    end
  endtask

  task automatic model_reset();
    m_win = 0; m_fill = 0; m_locked = 1'b0; m_pos = 0; m_miss = 0;
    m_sel = 0; m_good = 0; exp_vld = 1'b0; exp_err = 1'b0;
  endtask

  task automatic apply_stimulus(input logic b, input logic v);
    bit_in  = b;
    bit_vld = v;
    model_step(b, v);
    @(posedge iclk);
    #1;
    check_output("det_vld", 32'(det_vld), 32'(exp_vld));
    check_output("det_err", 32'(det_err), 32'(exp_err));
    check_output("det_sel", 32'(det_sel), 32'(m_sel));
    check_output("locked", 32'(locked), 32'(m_locked));
    check_output("good_cnt", 32'(good_cnt), 32'(m_good));
  endtask

  task automatic send_word(input logic [19:0] w, input int max_gap);
    int gap;
    for (int i = 19; i >= 0; i--) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) apply_stimulus(1'($urandom), 1'b0);
      apply_stimulus(w[i], 1'b1);
    end
  endtask

  task automatic do_reset();
    irst    = 1'b1;
    bit_vld = 1'b0;
    @(posedge iclk);
    #1;
    check_output("rst_det_vld", 32'(det_vld), 32'd0);
    check_output("rst_det_err", 32'(det_err), 32'd0);
    check_output("rst_det_sel", 32'(det_sel), 32'd0);
    check_output("rst_locked", 32'(locked), 32'd0);
    check_output("rst_good_cnt", 32'(good_cnt), 32'd0);
    model_reset();
    irst = 1'b0;
  endtask

  initial begin
    logic [6:0]  junk;
    logic [19:0] p2w;
    logic [19:0] rnd;
    checks  = 0;
    errors  = 0;
    pat[0]  = 20'h96A5A;
    pat[1]  = 20'hF0E5A;
    pat[2]  = 20'hAAA5A;
    pat[3]  = 20'h5565A;
    irst    = 1'b1;
    bit_in  = 1'b0;
    bit_vld = 1'b0;
    model_reset();
    @(posedge iclk);
    #1;
    do_reset();

    // First acquisition, then back-to-back locked frames.
    send_word(pat[2], 0);
    check_output("s1_sel", 32'(det_sel), 32'd2);
    check_output("s1_good", 32'(good_cnt), 32'd1);
    check_output("s1_locked", 32'(locked), 32'd1);
    send_word(pat[0], 0);
    send_word(pat[3], 0);
    check_output("s2_sel", 32'(det_sel), 32'd3);
    check_output("s2_good", 32'(good_cnt), 32'd3);

    // A good frame between misses restarts the miss count.
    send_word(20'h00000, 0);
    send_word(pat[1], 0);
    send_word(20'h00000, 0);
    send_word(20'h00000, 0);
    check_output("s3_still_locked", 32'(locked), 32'd1);
    send_word(20'h00000, 0);
    check_output("s3_unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0);

    // Unaligned search through junk.
    do_reset();
    junk = 7'b1011001;
    for (int i = 6; i >= 0; i--) apply_stimulus(junk[i], 1'b1);
    send_word(pat[1], 0);
    check_output("s4_sel", 32'(det_sel), 32'd1);
    check_output("s4_good", 32'(good_cnt), 32'd1);

    // Idle gaps inside a locked frame.
    send_word(pat[3], 5);
    check_output("s5_sel", 32'(det_sel), 32'd3);
    check_output("s5_good", 32'(good_cnt), 32'd2);

    // Reset in the middle of a frame drops the partial bits.
    p2w = pat[2];
    for (int i = 19; i >= 8; i--) apply_stimulus(p2w[i], 1'b1);
    do_reset();
    send_word(pat[2], 0);
    check_output("s6_good", 32'(good_cnt), 32'd1);
    check_output("s6_sel", 32'(det_sel), 32'd2);

    // Long random run: mixed patterns, junk frames, stray bits and gaps.
    for (int f = 0; f < 400; f++) begin
      if ($urandom_range(0, 99) < 85) begin
        send_word(pat[$urandom_range(0, 3)], (f % 4 == 0) ? 3 : 0);
      end else begin
        rnd = 20'($urandom);
        send_word(rnd, 2);
      end
      if ($urandom_range(0, 99) < 5) apply_stimulus(1'($urandom), 1'b1);
    end
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
